pkt_xmtr: RTL

Upstream companion of the serial packet receiver (rcvr). It accepts parallel bytes through a write handshake and buffers them in a small FIFO. Each byte is sent as one 16-bit serial packet: an 8-bit header, then the 8-bit body, both MSB first, one bit per clock. Its serial output drives the receiver's data_in directly.

---
 rtl/pkt_xmtr.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/pkt_xmtr.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pkt_xmtr
//  Purpose  : Serial packet transmitter. Parallel bytes are written into a
//             small circular FIFO. Each byte is sent as one 16-bit packet:
//             an 8-bit header (HEAD) followed by the byte itself, both MSB
//             first, one bit per clock. A configurable number of idle zero
//             cycles (GAP) may separate consecutive packets.
//  Ports    : clock      - rising-edge clock
//             reset      - synchronous, active-high reset
//             byte_in    - byte to enqueue
//             writing    - write strobe (byte_in sampled when high)
//             full       - FIFO holds DEPTH bytes
//             overflow   - one-cycle pulse when a write is dropped
//             count      - bytes buffered, excluding the byte in flight
//             serial_out - serial line (header then body, MSB first)
//             busy       - high while a packet or its trailing gap is active
//  Revision : 1.0 - initial release
// ============================================================================
module pkt_xmtr #(
    parameter int         DEPTH = 4,
    parameter logic [7:0] HEAD  = 8'hA5,
    parameter int         GAP   = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [7:0]               byte_in,
    input  logic                     writing,
    output logic                     full,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     serial_out,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);
    // Gap counter only needs to hold GAP; keep at least one bit so the
    // declaration stays legal when GAP is 0 or 1.
    localparam int GW = (GAP > 1) ? $clog2(GAP + 1) : 1;
    localparam logic [AW:0]   c_full_count = (AW + 1)'(DEPTH);
    localparam logic [GW-1:0] c_gap_load   = GW'(GAP);
    localparam logic [GW-1:0] c_gap_last   = GW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HEAD = 2'd1,
        S_BODY = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_full;
    logic          r_overflow;

    // Transmit state machine
    state_t        r_state;
    logic [2:0]    r_k;
    logic [7:0]    r_shift;
    logic [GW-1:0] r_gap;
    logic          r_serial;
    logic          r_busy;

    logic          w_have;
    logic          w_body_end;
    logic          w_gap_end;
    logic          w_pop;
    logic          w_accept;
    logic [AW:0]   w_count_next;
    logic [7:0]    w_head_byte;

    assign w_have      = (r_count != '0);
    assign w_body_end  = (r_state == S_BODY) && (r_k == 3'd0);
    assign w_gap_end   = (r_state == S_GAP) && (r_gap == c_gap_last);
    assign w_head_byte = r_mem[r_rd_ptr];

    // A pop happens on every edge that starts a new packet. With GAP=0 the
    // next packet follows the last body bit directly, otherwise it waits for
    // the gap to expire.
    assign w_pop = w_have && ((r_state == S_IDLE) ||
                              (w_body_end && (GAP == 0)) ||
                              w_gap_end);

    // A pop on the same edge frees a slot, so a full FIFO can still accept.
    assign w_accept = writing && ((r_count != c_full_count) || w_pop);

    always_comb begin
        w_count_next = r_count;
        if (w_accept && !w_pop) begin
            w_count_next = r_count + (AW + 1)'(1);
        end else if (!w_accept && w_pop) begin
            w_count_next = r_count - (AW + 1)'(1);
        end
    end

    // Storage carries no reset; stale contents are never read because the
    // pointers and count are cleared.
    always_ff @(posedge clock) begin
        if (!reset && w_accept) begin
            r_mem[r_wr_ptr] <= byte_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count    <= w_count_next;
            r_full     <= (w_count_next == c_full_count);
            r_overflow <= writing && !w_accept;
        end
    end

    // serial_out and busy are registered together with the state, so each
    // transition also loads the bit that belongs to the state being entered.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_k      <= 3'd0;
            r_shift  <= 8'h00;
            r_gap    <= '0;
            r_serial <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_shift  <= w_head_byte;
                        r_k      <= 3'd7;
                        r_state  <= S_HEAD;
                        r_serial <= HEAD[7];
                        r_busy   <= 1'b1;
                    end else begin
                        r_serial <= 1'b0;
                        r_busy   <= 1'b0;
                    end
                end

                S_HEAD: begin
                    if (r_k == 3'd0) begin
                        r_state  <= S_BODY;
                        r_k      <= 3'd7;
                        r_serial <= r_shift[7];
                    end else begin
                        r_k      <= r_k - 3'd1;
                        r_serial <= HEAD[r_k - 3'd1];
                    end
                end

                S_BODY: begin
                    if (r_k == 3'd0) begin
                        if (GAP > 0) begin
                            r_state  <= S_GAP;
                            r_gap    <= c_gap_load;
                            r_serial <= 1'b0;
                        end else if (w_pop) begin
                            r_shift  <= w_head_byte;
                            r_k      <= 3'd7;
                            r_state  <= S_HEAD;
                            r_serial <= HEAD[7];
                        end else begin
                            r_state  <= S_IDLE;
                            r_serial <= 1'b0;
                            r_busy   <= 1'b0;
                        end
                    end else begin
                        r_k      <= r_k - 3'd1;
                        r_serial <= r_shift[r_k - 3'd1];
                    end
                end

                S_GAP: begin
                    if (r_gap == c_gap_last) begin
                        if (w_pop) begin
                            r_shift  <= w_head_byte;
                            r_k      <= 3'd7;
                            r_state  <= S_HEAD;
                            r_serial <= HEAD[7];
                        end else begin
                            r_state  <= S_IDLE;
                            r_serial <= 1'b0;
                            r_busy   <= 1'b0;
                        end
                    end else begin
                        r_gap    <= r_gap - c_gap_last;
                        r_serial <= 1'b0;
                    end
                end

                default: begin
                    r_state  <= S_IDLE;
                    r_serial <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign full       = r_full;
    assign overflow   = r_overflow;
    assign count      = r_count;
    assign serial_out = r_serial;
    assign busy       = r_busy;

endmodule
`default_nettype wire
